// File: rtl/time_alarm_core.sv
// BCD timekeeping and alarm datapath: HH:MM:SS clock, HH:MM alarm, field adjust and ring control.
// Optional snooze support is compiled in when SNOOZE_EN is defined.
module time_alarm_core #(
  parameter int unsigned RING_SECS    = 60,
  parameter int unsigned ALARM_RST_HH = 6,
  parameter int unsigned SNOOZE_MIN   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic [2:0]  adj_sel,
  input  logic        inc,
  input  logic        dec,
  input  logic        alarm_arm,
  input  logic        alarm_stop,
  input  logic        alarm_snooze,
  output logic [15:0] digits,
  output logic [7:0]  secs,
  output logic        show_alarm,
  output logic        alarm_ringing,
  output logic        sec_blink
);

  // Fields are held in binary and converted to BCD on the way out, so no
  // output digit can ever pass through a non-BCD value.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  function automatic logic [5:0] step_min(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] step_hr(input logic [4:0] v, input logic up);
    if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    else    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  logic [5:0] sec_q, sec_d, min_q, min_d, amin_q, amin_d;
  logic [4:0] hr_q, hr_d, ahr_q, ahr_d;
  logic       blink_q, blink_d, ring_q, ring_d, show_q, show_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;

  logic clk_adj, alm_adj, step, tick_ok, adj_ok, at_zero, alarm_hit, ring_clr;
  logic snz_req, snz_hit;

  always_comb begin
    clk_adj = (adj_sel == 3'd1) || (adj_sel == 3'd2);
    alm_adj = (adj_sel == 3'd3) || (adj_sel == 3'd4);
    step    = inc ^ dec;
    tick_ok = tick_1hz && !clk_adj;
    adj_ok  = step && (clk_adj || alm_adj);
    show_d  = alm_adj;
  end

  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    blink_d = blink_q;
    amin_d  = amin_q;
    ahr_d   = ahr_q;
    if (tick_ok) begin
      blink_d = !blink_q;
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else if (clk_adj && step) begin
      sec_d = 6'd0;
      if (adj_sel == 3'd1) min_d = step_min(min_q, inc);
      else                 hr_d  = step_hr(hr_q, inc);
    end
    if (alm_adj && step) begin
      if (adj_sel == 3'd3) amin_d = step_min(amin_q, inc);
      else                 ahr_d  = step_hr(ahr_q, inc);
    end
  end

  // Matches only fire on the tick that rolls seconds to :00, never on an adjust.
  always_comb begin
    at_zero   = tick_ok && (sec_q == 6'd59);
    alarm_hit = at_zero && alarm_arm && (min_d == amin_q) && (hr_d == ahr_q);
  end

`ifdef SNOOZE_EN
  logic       snz_act_q, snz_act_d, snz_cancel;
  logic [5:0] snz_min_q, snz_min_d;
  logic [4:0] snz_hr_q, snz_hr_d;
  logic [6:0] snz_sum;

  always_comb begin
    snz_cancel = alarm_stop || !alarm_arm || (alm_adj && step);
    snz_req    = alarm_snooze && ring_q;
    snz_hit    = snz_act_q && at_zero && alarm_arm &&
                 (min_d == snz_min_q) && (hr_d == snz_hr_q);
    snz_sum    = {1'b0, min_q} + 7'(SNOOZE_MIN);
    snz_act_d  = snz_act_q;
    snz_min_d  = snz_min_q;
    snz_hr_d   = snz_hr_q;
    if (snz_cancel) begin
      snz_act_d = 1'b0;
    end else if (snz_req) begin
      snz_act_d = 1'b1;
      if (snz_sum >= 7'd60) begin
        snz_min_d = 6'(snz_sum - 7'd60);
        snz_hr_d  = step_hr(hr_q, 1'b1);
      end else begin
        snz_min_d = snz_sum[5:0];
        snz_hr_d  = hr_q;
      end
    end else if (snz_hit) begin
      snz_act_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snz_act_q <= 1'b0;
      snz_min_q <= 6'd0;
      snz_hr_q  <= 5'd0;
    end else begin
      snz_act_q <= snz_act_d;
      snz_min_q <= snz_min_d;
      snz_hr_q  <= snz_hr_d;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = ^{alarm_snooze, 7'(SNOOZE_MIN)};

  always_comb begin
    snz_req = 1'b0;
    snz_hit = 1'b0;
  end
`endif

  // Clear wins over set when both occur on the same edge.
  always_comb begin
    ring_clr   = alarm_stop || !alarm_arm || adj_ok || snz_req;
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    if (ring_clr) begin
      ring_d     = 1'b0;
      ring_cnt_d = 8'd0;
    end else if (alarm_hit || snz_hit) begin
      ring_d     = 1'b1;
      ring_cnt_d = 8'(RING_SECS);
    end else if (ring_q && tick_ok) begin
      if (ring_cnt_q <= 8'd1) begin
        ring_d     = 1'b0;
        ring_cnt_d = 8'd0;
      end else begin
        ring_cnt_d = ring_cnt_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hr_q       <= 5'd0;
      amin_q     <= 6'd0;
      ahr_q      <= 5'(ALARM_RST_HH);
      blink_q    <= 1'b0;
      ring_q     <= 1'b0;
      ring_cnt_q <= 8'd0;
      show_q     <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      amin_q     <= amin_d;
      ahr_q      <= ahr_d;
      blink_q    <= blink_d;
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
      show_q     <= show_d;
    end
  end

  always_comb begin
    if (show_q) digits = {to_bcd({2'b0, ahr_q}), to_bcd({1'b0, amin_q})};
    else        digits = {to_bcd({2'b0, hr_q}), to_bcd({1'b0, min_q})};
    secs          = to_bcd({1'b0, sec_q});
    show_alarm    = show_q;
    alarm_ringing = ring_q;
    sec_blink     = blink_q;
  end

endmodule

// File: doc/time_alarm_core.md
Name: time_alarm_core

Overview:
BCD timekeeping and alarm datapath that sits directly downstream of the mode/adjust state machine and upstream of the 4-digit display mux. It keeps HH:MM:SS plus an alarm HH:MM and applies single-step inc/dec commands to the field the FSM selects. It presents the four display digits, either the running time or the alarm time. It raises a ringing flag on an alarm match.

Parameters:
RING_SECS, 60, seconds alarm_ringing stays asserted before it self-clears (1..255)
ALARM_RST_HH, 6, alarm hours value after reset (0..23); alarm minutes reset to 00
SNOOZE_MIN, 5, snooze delay in minutes (1..59); used only with SNOOZE_EN

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick_1hz  in  1  one-clk-wide pulse once per second, synchronous to clk
adj_sel  in  3  0=run, 1=clock min, 2=clock hr, 3=alarm min, 4=alarm hr; 5-7 treated as 0
inc  in  1  one-clk pulse (debounced upstream): increment selected field
dec  in  1  one-clk pulse: decrement selected field
alarm_arm  in  1  level: alarm enabled
alarm_stop  in  1  one-clk pulse: silence ringing alarm
alarm_snooze  in  1  one-clk pulse: snooze (ignored unless SNOOZE_EN)
digits  out  16  {hr_tens[3:0], hr_ones, min_tens, min_ones}, BCD
secs  out  8  {sec_tens, sec_ones} of running time, BCD
show_alarm  out  1  1 when digits shows the alarm time
alarm_ringing  out  1  alarm active
sec_blink  out  1  toggles on every accepted tick_1hz (drives colon DP)

Behaviour:
- Reset (async, immediate): time 00:00:00; alarm ALARM_RST_HH:00; alarm_ringing=0; sec_blink=0; ring counter=0; snooze inactive. All outputs are registered or decoded from registers only.
- Time counting: on tick_1hz with adj_sel not 1 or 2, secs advance. 59->00 carries into minutes. Minutes 59->00 carries into hours. Hours 23->00. All digits stay valid BCD at all times; there is never an intermediate non-BCD value.
- Clock adjust (adj_sel 1/2): tick_1hz is ignored and the time is frozen. sec_blink holds. inc/dec steps only the selected field: minutes 00..59, hours 00..23. Both wrap in both directions with no carry or borrow into the neighbour field. Any accepted inc/dec on a clock field also clears secs to 00.
- Alarm adjust (adj_sel 3/4): the clock keeps running. inc/dec steps alarm minutes or hours with the same wrap rules.
- Updates take effect on the clk edge that samples the pulse. digits reflects the new value one cycle after the pulse.
- inc and dec asserted in the same cycle: no change. inc/dec with adj_sel=0: ignored.
- Display: show_alarm=1 iff adj_sel is 3 or 4. digits then shows the alarm time; otherwise it shows the running time.
- Match: the match is evaluated on the tick that makes the time reach HH:MM:00 equal to the alarm. It requires alarm_arm=1 and adj_sel not 1 or 2. On a match, alarm_ringing is set on that same edge. Changing the time or alarm so that the current time equals the alarm does not trigger.
- Ringing: a counter is loaded with RING_SECS at set and decrements on each accepted tick. alarm_ringing clears when the counter reaches 0.
- alarm_ringing also clears on alarm_stop, on alarm_arm=0, or on any accepted inc/dec. Clear has priority over set in the same cycle.
- Ringing does not retrigger within the same matching minute.
- Reset mid-ring: alarm_ringing drops asynchronously.

Optional Feature:
SNOOZE_EN
- With the macro defined:
  - alarm_snooze while ringing clears alarm_ringing and arms a snooze target of current time + SNOOZE_MIN minutes, with wrap across hours and midnight, at :00.
  - When the time reaches that target with alarm_arm=1, the alarm rings again.
  - The target is cancelled by alarm_stop, alarm_arm=0, or any alarm-field adjust.
  - Snoozes may repeat indefinitely.
- Without the macro: the alarm_snooze port remains, but it is ignored and no snooze state is synthesised.

Test Plan:
- Reset, then 3661 ticks with adj_sel=0 -> digits=16'h0101, secs=8'h01, sec_blink=1.
- Time 23:59:58, two ticks -> 00:00:00 (digits=16'h0000, secs=8'h00).
- adj_sel=1 at 12:00:37: dec -> 12:59:00 with hours unchanged. adj_sel=2, inc x13 -> 01:59:00. Ticks during adjust leave the time unchanged.
- Alarm 07:30, armed, time 07:29:59, one tick -> alarm_ringing=1 on that edge. 60 further ticks -> alarm_ringing=0, with no retrigger at 07:30 seconds.
- Ringing plus alarm_stop in the same cycle as a tick -> alarm_ringing=0 next cycle. inc and dec together with adj_sel=3 -> alarm unchanged.
- (SNOOZE_EN, SNOOZE_MIN=5) alarm 23:58 rings, snooze at 23:58:10 -> silent, re-rings at 00:03:00. The same stimulus without the macro never re-rings.
